// File: rtl/lane_rr_scheduler_l1_if.sv
`default_nettype none
// ============================================================================
// Module      : lane_rr_scheduler_l1_if
// Description : Bus bundle for the four-lane round-robin Rx scheduler.
//               master = upstream demux / downstream sink side (drives lane
//               bytes, enable, ready_in, clear_ovf); slave = the scheduler.
// Signals     : valid_in0..3 / data_in0..3  per-lane byte and valid
//               enable, ready_in, clear_ovf  control into the scheduler
//               valid_out, data_out, lane_out scheduled byte and source lane
//               fifo_full, fifo_empty        per-lane FIFO status
//               overflow                     sticky per-lane drop flags
// Revision    : 1.0 - initial release
// ============================================================================
interface lane_rr_scheduler_l1_if;
  logic       valid_in0;
  logic       valid_in1;
  logic       valid_in2;
  logic       valid_in3;
  logic [7:0] data_in0;
  logic [7:0] data_in1;
  logic [7:0] data_in2;
  logic [7:0] data_in3;
  logic       enable;
  logic       ready_in;
  logic       clear_ovf;
  logic       valid_out;
  logic [7:0] data_out;
  logic [1:0] lane_out;
  logic [3:0] fifo_full;
  logic [3:0] fifo_empty;
  logic [3:0] overflow;

  modport master (
    output valid_in0, valid_in1, valid_in2, valid_in3,
    output data_in0, data_in1, data_in2, data_in3,
    output enable, ready_in, clear_ovf,
    input  valid_out, data_out, lane_out,
    input  fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    input  data_in0, data_in1, data_in2, data_in3,
    input  enable, ready_in, clear_ovf,
    output valid_out, data_out, lane_out,
    output fifo_full, fifo_empty, overflow
  );
endinterface
`default_nettype wire

// File: rtl/lane_rr_scheduler_l1.sv
`default_nettype none
// ============================================================================
// Module      : lane_rr_scheduler_l1
// Description : Rx-side scheduler behind the 2-to-4 lane demux. Buffers four
//               8-bit lanes in per-lane FIFOs and drains them round-robin onto
//               a single valid/ready byte port. Reports per-lane full/empty
//               status and sticky per-lane overflow flags.
// Ports       : clk_f    - sole clock, rising edge
//               reset_L  - asynchronous, active-low reset
//               bus      - slave side of lane_rr_scheduler_l1_if (lane inputs,
//                          enable/ready_in/clear_ovf, output word and status)
// Parameters  : DEPTH    - entries per lane FIFO (power of two, >= 2)
//               AW       - log2(DEPTH), pointer width; counts are AW+1 bits
// Revision    : 1.0 - initial release
// ============================================================================
module lane_rr_scheduler_l1 #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk_f,
  input  logic                  reset_L,
  lane_rr_scheduler_l1_if.slave bus
);

  localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Storage and control state
  // --------------------------------------------------------------------------
  logic [7:0]    mem_q    [4][DEPTH];
  logic [7:0]    mem_d    [4][DEPTH];
  logic [AW-1:0] wr_ptr_q [4];
  logic [AW-1:0] wr_ptr_d [4];
  logic [AW-1:0] rd_ptr_q [4];
  logic [AW-1:0] rd_ptr_d [4];
  logic [AW:0]   count_q  [4];
  logic [AW:0]   count_d  [4];

  logic [1:0]    rr_ptr_q;
  logic [1:0]    rr_ptr_d;
  state_t        state_q;
  state_t        state_d;
  logic          valid_out_q;
  logic          valid_out_d;
  logic [7:0]    data_out_q;
  logic [7:0]    data_out_d;
  logic [1:0]    lane_out_q;
  logic [1:0]    lane_out_d;
  logic [3:0]    overflow_q;
  logic [3:0]    overflow_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [7:0]    w_din [4];
  logic [3:0]    w_vin;
  logic [3:0]    w_empty;
  logic [3:0]    w_full;
  logic [3:0]    w_push;
  logic [3:0]    w_pop;
  logic [3:0]    w_drop;
  logic          w_any;
  logic          w_load;
  logic          w_found;
  logic [1:0]    w_grant;
  logic [7:0]    w_head;

  assign w_vin    = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
  assign w_din[0] = bus.data_in0;
  assign w_din[1] = bus.data_in1;
  assign w_din[2] = bus.data_in2;
  assign w_din[3] = bus.data_in3;

  for (genvar n = 0; n < 4; n++) begin : g_lane
    assign w_empty[n] = (count_q[n] == '0);
    assign w_full[n]  = (count_q[n] == c_full_cnt);
    // A full lane still accepts when its head leaves this same cycle, so a
    // lane streaming at full rate never drops while it is being drained.
    assign w_push[n]  = w_vin[n] & (~w_full[n] | w_pop[n]);
    assign w_drop[n]  = w_vin[n] & ~w_push[n];
  end

  assign w_any = |(~w_empty);

  // Output stage is free when it is empty or its word leaves this cycle.
  assign w_load = bus.enable & (~valid_out_q | bus.ready_in) & w_any;

  // Round-robin search: first non-empty lane at or after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_grant = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && !w_empty[rr_ptr_q + 2'(i)]) begin
        w_found = 1'b1;
        w_grant = rr_ptr_q + 2'(i);
      end
    end
  end

  assign w_head = mem_q[w_grant][rd_ptr_q[w_grant]];
  assign w_pop  = w_load ? (4'b0001 << w_grant) : 4'b0000;

  // --------------------------------------------------------------------------
  // Per-lane FIFO next state
  // --------------------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int n = 0; n < 4; n++) begin
      if (w_push[n]) begin
        mem_d[n][wr_ptr_q[n]] = w_din[n];
        wr_ptr_d[n]           = wr_ptr_q[n] + AW'(1);
      end
      if (w_pop[n]) begin
        rd_ptr_d[n] = rd_ptr_q[n] + AW'(1);
      end
      count_d[n] = count_q[n] + (AW+1)'(w_push[n]) - (AW+1)'(w_pop[n]);
    end
  end

  // --------------------------------------------------------------------------
  // Output stage FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    lane_out_d  = lane_out_q;
    rr_ptr_d    = rr_ptr_q;

    // A load can only occur while the stage is empty or handing off, so the
    // held word in WAIT is never overwritten.
    if (w_load) begin
      data_out_d = w_head;
      lane_out_d = w_grant;
      rr_ptr_d   = w_grant + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_load) begin
          state_d     = ST_SEND;
          valid_out_d = 1'b1;
        end
      end
      ST_SEND, ST_WAIT: begin
        if (bus.ready_in) begin
          if (w_load) begin
            state_d     = ST_SEND;
            valid_out_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            valid_out_d = 1'b0;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        valid_out_d = 1'b0;
      end
    endcase
  end

  // A drop in the same cycle as clear_ovf must still be recorded.
  assign overflow_d = w_drop | (bus.clear_ovf ? 4'b0000 : overflow_q);

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      for (int n = 0; n < 4; n++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_q[n][e] <= '0;
        end
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        count_q[n]  <= '0;
      end
      rr_ptr_q    <= 2'd0;
      state_q     <= ST_IDLE;
      valid_out_q <= 1'b0;
      data_out_q  <= 8'h00;
      lane_out_q  <= 2'd0;
      overflow_q  <= 4'h0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      lane_out_q  <= lane_out_d;
      overflow_q  <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.valid_out  = valid_out_q;
  assign bus.data_out   = data_out_q;
  assign bus.lane_out   = lane_out_q;
  assign bus.fifo_full  = w_full;
  assign bus.fifo_empty = w_empty;
  assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_lane_rr_scheduler_l1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lane_rr_scheduler_l1
// Description : Self-checking bench for lane_rr_scheduler_l1. A queue-based
//               reference model predicts the output word, lane, FIFO status
//               and overflow flags every cycle; directed scenarios are
//               followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_rr_scheduler_l1;

  localparam int DEPTH = 4;

  logic clk_f   = 1'b0;
  logic reset_L = 1'b0;

  lane_rr_scheduler_l1_if bus ();

  lane_rr_scheduler_l1 #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_f = ~clk_f;

  // Stimulus
  logic [3:0] vin = 4'h0;
  logic [7:0] din [4];
  logic       enable    = 1'b0;
  logic       ready_in  = 1'b0;
  logic       clear_ovf = 1'b0;

  assign bus.valid_in0 = vin[0];
  assign bus.valid_in1 = vin[1];
  assign bus.valid_in2 = vin[2];
  assign bus.valid_in3 = vin[3];
  assign bus.data_in0  = din[0];
  assign bus.data_in1  = din[1];
  assign bus.data_in2  = din[2];
  assign bus.data_in3  = din[3];
  assign bus.enable    = enable;
  assign bus.ready_in  = ready_in;
  assign bus.clear_ovf = clear_ovf;

  // Reference model: one queue per lane plus the held output word.
  logic [7:0] mq [4][$];
  int         m_rr;
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_lane;
  logic [3:0] m_ovf;

  // Words seen leaving the DUT, as {lane, data}.
  logic [9:0] seen_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] seen_at(input int i);
    return (i < seen_q.size()) ? seen_q[i] : 10'h3FF;
  endfunction

  function automatic logic [3:0] m_full();
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = (mq[n].size() == DEPTH);
    return r;
  endfunction

  function automatic logic [3:0] m_empty();
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = (mq[n].size() == 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) mq[n].delete();
    m_rr    = 0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_lane  = 2'd0;
    m_ovf   = 4'h0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int         g;
    bit         load;
    bit         xfer;
    logic [7:0] popped;
    g = -1;
    popped = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (g < 0 && mq[(m_rr + i) % 4].size() > 0) g = (m_rr + i) % 4;
    end
    load = enable && (!m_valid || ready_in) && (g >= 0);
    xfer = m_valid && ready_in;
    if (load) popped = mq[g].pop_front();
    if (clear_ovf) m_ovf = 4'h0;
    for (int n = 0; n < 4; n++) begin
      if (vin[n]) begin
        if (mq[n].size() < DEPTH) mq[n].push_back(din[n]);
        else m_ovf[n] = 1'b1;
      end
    end
    if (load) begin
      m_valid = 1'b1;
      m_data  = popped;
      m_lane  = 2'(g);
      m_rr    = (g + 1) % 4;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".valid_out"},  32'(bus.valid_out),  32'(m_valid));
    check({ph, ".data_out"},   32'(bus.data_out),   32'(m_data));
    check({ph, ".lane_out"},   32'(bus.lane_out),   32'(m_lane));
    check({ph, ".fifo_full"},  32'(bus.fifo_full),  32'(m_full()));
    check({ph, ".fifo_empty"}, 32'(bus.fifo_empty), 32'(m_empty()));
    check({ph, ".overflow"},   32'(bus.overflow),   32'(m_ovf));
  endtask

  // One clock: record any handshake, advance the model, compare after the edge.
  task automatic step(input string ph);
    if (bus.valid_out && ready_in) seen_q.push_back({bus.lane_out, bus.data_out});
    model_step();
    @(posedge clk_f);
    #1;
    check_outputs(ph);
  endtask

  // Reset asserted away from the clock edge so its asynchronous effect shows.
  task automatic apply_reset(input string ph);
    reset_L = 1'b0;
    #1;
    model_reset();
    check({ph, ".async_valid"}, 32'(bus.valid_out),  32'h0);
    check({ph, ".async_data"},  32'(bus.data_out),   32'h00);
    check({ph, ".async_lane"},  32'(bus.lane_out),   32'h0);
    check({ph, ".async_empty"}, 32'(bus.fifo_empty), 32'hF);
    repeat (3) @(posedge clk_f);
    #1;
    check({ph, ".hold_valid"}, 32'(bus.valid_out),  32'h0);
    check({ph, ".hold_empty"}, 32'(bus.fifo_empty), 32'hF);
    check({ph, ".hold_full"},  32'(bus.fifo_full),  32'h0);
    check({ph, ".hold_ovf"},   32'(bus.overflow),   32'h0);
    check({ph, ".hold_lane"},  32'(bus.lane_out),   32'h0);
    reset_L = 1'b1;
  endtask

  initial begin
    for (int n = 0; n < 4; n++) din[n] = 8'h00;
    model_reset();
    #2;

    // Reset
    apply_reset("rst");

    // Single lane: two bytes on lane 2
    enable   = 1'b1;
    ready_in = 1'b1;
    seen_q.delete();
    vin = 4'b0100; din[2] = 8'hA5; step("t2");
    din[2] = 8'h3C;                step("t2");
    vin = 4'h0;
    repeat (4) step("t2");
    check("t2.count", 32'(seen_q.size()), 32'd2);
    check("t2.w0", 32'(seen_at(0)), {22'd0, 2'd2, 8'hA5});
    check("t2.w1", 32'(seen_at(1)), {22'd0, 2'd2, 8'h3C});

    // Fairness: two identical all-lane bursts from rr_ptr=0
    apply_reset("t3rst");
    seen_q.delete();
    for (int b = 0; b < 2; b++) begin
      vin = 4'hF;
      for (int n = 0; n < 4; n++) din[n] = 8'h10 + 8'(n);
      step("t3");
      vin = 4'h0;
      repeat (6) step("t3");
    end
    check("t3.count", 32'(seen_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3.w%0d", i), 32'(seen_at(i)), {22'd0, 2'(i % 4), 8'h10 + 8'(i % 4)});

    // Backpressure and overflow on lane 0
    ready_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      vin = 4'b0001; din[0] = 8'(k);
      step("t4");
    end
    vin = 4'h0;
    step("t4");
    check("t4.held", 32'(bus.data_out), 32'h01);
    check("t4.full0", 32'(bus.fifo_full[0]), 32'h1);
    check("t4.ovf0", 32'(bus.overflow[0]), 32'h1);
    seen_q.delete();
    ready_in = 1'b1;
    repeat (8) step("t4");
    check("t4.count", 32'(seen_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t4.w%0d", i), 32'(seen_at(i)), {22'd0, 2'd0, 8'(i + 1)});

    // Overflow clear, then clear coinciding with a new lane 1 drop
    clear_ovf = 1'b1; step("t5");
    clear_ovf = 1'b0;
    check("t5.cleared", 32'(bus.overflow), 32'h0);
    ready_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      vin = 4'b0010; din[1] = 8'h21 + 8'(k);
      clear_ovf = (k == 5);
      step("t5");
    end
    vin = 4'h0; clear_ovf = 1'b0;
    check("t5.set_wins", 32'(bus.overflow[1]), 32'h1);
    ready_in = 1'b1;
    repeat (8) step("t5");

    // Reset in the middle of burst traffic
    vin = 4'hF;
    for (int n = 0; n < 4; n++) din[n] = 8'h10 + 8'(n);
    step("t6"); step("t6");
    vin = 4'h0;
    step("t6");
    apply_reset("t6rst");
    seen_q.delete();
    repeat (5) step("t6");
    check("t6.no_stale", 32'(seen_q.size()), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 4; n++) begin
        vin[n] = ($urandom_range(0, 9) < 4);
        din[n] = 8'($urandom);
      end
      ready_in  = ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 9) != 0);
      clear_ovf = ($urandom_range(0, 19) == 0);
      step("rnd");
    end
    vin = 4'h0; ready_in = 1'b1; enable = 1'b1; clear_ovf = 1'b0;
    repeat (30) step("drain");
    check("drain.empty", 32'(bus.fifo_empty), 32'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
